// File: rtl/led_matrix_scanner.sv
// Row-multiplexed ROWS x COLS common-anode LED matrix driver with a scan prescaler,
// inter-row blanking, selectable pin polarity and a frame buffer swapped at frame ends.
module led_matrix_scanner #(
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int DIV          = 1000,
  parameter int BLANK        = 16,
  parameter int ROW_ACT_HIGH = 1,
  parameter int COL_ACT_LOW  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROWS*COLS-1:0]   pixels,
  input  logic                   pixels_valid,
  output logic                   pixels_ready,
  output logic [ROWS-1:0]        rows,
  output logic [COLS-1:0]        cols,
  output logic                   frame_start
);

  localparam int NPIX   = ROWS * COLS;
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
  // Idle pin levels; XOR with these turns "active/lit" masks into pin levels.
  localparam logic [ROWS-1:0] ROW_IDLE = (ROW_ACT_HIGH != 0) ? {ROWS{1'b0}} : {ROWS{1'b1}};
  localparam logic [COLS-1:0] COL_IDLE = (COL_ACT_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

  generate
    if (ROWS < 1 || COLS < 1 || DIV < 2 || BLANK < 0 || BLANK >= DIV) begin : g_bad_params
      $error("led_matrix_scanner: illegal parameter combination");
    end
  endgenerate

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [NPIX-1:0]   active_q, active_d;
  logic [NPIX-1:0]   pending_q, pending_d;
  logic              pending_full_q, pending_full_d;
  logic [ROWS-1:0]   rows_q, rows_d;
  logic [COLS-1:0]   cols_q, cols_d;
  logic              frame_start_q, frame_start_d;

  logic                       frame_end;
  logic [ROWS-1:0][COLS-1:0]  active_rows;
  logic [ROWS-1:0]            row_on;

  assign frame_end   = (tick_q == TICK_LAST) && (row_q == ROW_LAST);
  assign active_rows = active_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q         <= {TICK_W{1'b0}};
      row_q          <= {ROW_W{1'b0}};
      active_q       <= {NPIX{1'b0}};
      pending_q      <= {NPIX{1'b0}};
      pending_full_q <= 1'b0;
      rows_q         <= ROW_IDLE;
      cols_q         <= COL_IDLE;
      frame_start_q  <= 1'b0;
    end else begin
      tick_q         <= tick_d;
      row_q          <= row_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      rows_q         <= rows_d;
      cols_q         <= cols_d;
      frame_start_q  <= frame_start_d;
    end
  end

  always_comb begin
    tick_d = tick_q;
    row_d  = row_q;
    if (tick_q == TICK_LAST) begin
      tick_d = {TICK_W{1'b0}};
      if (row_q == ROW_LAST) begin
        row_d = {ROW_W{1'b0}};
      end else begin
        row_d = row_q + 1'b1;
      end
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  // The pending slot only fills when empty, so a load and an accept never coincide.
  always_comb begin
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    frame_start_d  = frame_end;
    if (frame_end && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end else if (pixels_valid && !pending_full_q) begin
      pending_d      = pixels;
      pending_full_d = 1'b1;
    end else begin
      pending_full_d = pending_full_q;
    end
  end

  always_comb begin
    row_on = {ROWS{1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      row_on[r] = (row_q == ROW_W'(r));
    end
    if (tick_q < TICK_BLANK) begin
      rows_d = ROW_IDLE;
      cols_d = COL_IDLE;
    end else begin
      rows_d = row_on ^ ROW_IDLE;
      cols_d = active_rows[row_q] ^ COL_IDLE;
    end
  end

  assign pixels_ready = !pending_full_q;
  assign rows         = rows_q;
  assign cols         = cols_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: a 3x3 default-polarity instance and a 4x5
// inverted-polarity instance, each checked every cycle against a frame-queue model.
module tb_led_matrix_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, val_a, rdy_a, fs_a;
  logic [8:0]  pix_a;
  logic [2:0]  rows_a, cols_a;
  logic        rst_b, val_b, rdy_b, fs_b;
  logic [19:0] pix_b;
  logic [3:0]  rows_b;
  logic [4:0]  cols_b;

  led_matrix_scanner #(.ROWS(3), .COLS(3), .DIV(8), .BLANK(2),
                       .ROW_ACT_HIGH(1), .COL_ACT_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .pixels(pix_a), .pixels_valid(val_a),
    .pixels_ready(rdy_a), .rows(rows_a), .cols(cols_a), .frame_start(fs_a));

  led_matrix_scanner #(.ROWS(4), .COLS(5), .DIV(8), .BLANK(2),
                       .ROW_ACT_HIGH(0), .COL_ACT_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .pixels(pix_b), .pixels_valid(val_b),
    .pixels_ready(rdy_b), .rows(rows_b), .cols(cols_b), .frame_start(fs_b));

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: edges since reset, displayed frame, and a scoreboard of accepted frames.
  int          a_cnt, b_cnt;
  logic [8:0]  a_active;
  logic [19:0] b_active;
  logic        a_full, b_full;
  logic [8:0]  sb_a[$];
  logic [19:0] sb_b[$];
  logic [2:0]  ea_rows, ea_cols;
  logic [3:0]  eb_rows;
  logic [4:0]  eb_cols;
  logic        ea_fs, eb_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, req);
    end
  endtask

  task automatic cycle();
    int  t, r;
    logic bnd, acc;
    @(posedge clk);
    if (!rst_a) begin
      a_cnt = 0; a_active = '0; a_full = 1'b0; sb_a.delete();
      ea_rows = 3'b000; ea_cols = 3'b111; ea_fs = 1'b0;
    end else begin
      t = a_cnt % 8; r = (a_cnt / 8) % 3;
      bnd = (t == 7) && (r == 2);
      if (t < 2) begin
        ea_rows = 3'b000; ea_cols = 3'b111;
      end else begin
        ea_rows = 3'b001 << r; ea_cols = ~a_active[r*3 +: 3];
      end
      ea_fs = bnd;
      acc = val_a && !a_full;
      if (bnd && a_full) begin a_active = sb_a.pop_front(); a_full = 1'b0; end
      if (acc) begin sb_a.push_back(pix_a); a_full = 1'b1; end
      a_cnt++;
    end
    if (!rst_b) begin
      b_cnt = 0; b_active = '0; b_full = 1'b0; sb_b.delete();
      eb_rows = 4'b1111; eb_cols = 5'b00000; eb_fs = 1'b0;
    end else begin
      t = b_cnt % 8; r = (b_cnt / 8) % 4;
      bnd = (t == 7) && (r == 3);
      if (t < 2) begin
        eb_rows = 4'b1111; eb_cols = 5'b00000;
      end else begin
        eb_rows = ~(4'b0001 << r); eb_cols = b_active[r*5 +: 5];
      end
      eb_fs = bnd;
      acc = val_b && !b_full;
      if (bnd && b_full) begin b_active = sb_b.pop_front(); b_full = 1'b0; end
      if (acc) begin sb_b.push_back(pix_b); b_full = 1'b1; end
      b_cnt++;
    end
    @(negedge clk);
    chk($sformatf("a_rows@%0d", a_cnt), rows_a, ea_rows);
    chk($sformatf("a_cols@%0d", a_cnt), cols_a, ea_cols);
    chk($sformatf("a_fs@%0d", a_cnt), fs_a, ea_fs);
    chk($sformatf("a_ready@%0d", a_cnt), rdy_a, !a_full);
    chk($sformatf("b_rows@%0d", b_cnt), rows_b, eb_rows);
    chk($sformatf("b_cols@%0d", b_cnt), cols_b, eb_cols);
    chk($sformatf("b_fs@%0d", b_cnt), fs_b, eb_fs);
    chk($sformatf("b_ready@%0d", b_cnt), rdy_b, !b_full);
  endtask

  task automatic run_to(input int n);
    for (int k = 0; k < 400 && a_cnt < n; k++) cycle();
  endtask

  logic [8:0] frames[3];
  int sent, acc_edge[3];

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; val_a = 1'b0; val_b = 1'b0;
    pix_a = '0; pix_b = '0;
    a_cnt = 0; b_cnt = 0; a_active = '0; b_active = '0; a_full = 1'b0; b_full = 1'b0;
    frames[0] = 9'b000_000_111; frames[1] = 9'b010_101_010; frames[2] = 9'b100_100_100;
    @(negedge clk);
    repeat (3) cycle();
    chk("reset_rows_a", rows_a, 3'b000);
    chk("reset_cols_a", cols_a, 3'b111);
    chk("reset_ready_a", rdy_a, 1'b1);
    chk("reset_fs_a", fs_a, 1'b0);
    chk("reset_rows_b", rows_b, 4'b1111);
    chk("reset_cols_b", cols_b, 5'b00000);

    // Load and scan
    rst_a = 1'b1; rst_b = 1'b1;
    pix_a = 9'b111_010_001; val_a = 1'b1;
    pix_b = 20'h80000;      val_b = 1'b1;
    cycle();
    chk("ready_after_accept_a", rdy_a, 1'b0);
    chk("ready_after_accept_b", rdy_b, 1'b0);
    val_a = 1'b0; val_b = 1'b0;
    run_to(24);
    chk("fs_edge24", fs_a, 1'b1);
    run_to(28);
    chk("row0_rows", rows_a, 3'b001);
    chk("row0_cols", cols_a, 3'b110);
    chk("b_frame0_row3_rows", rows_b, 4'b0111);
    chk("b_frame0_row3_cols", cols_b, 5'b00000);
    run_to(32);
    chk("b_fs_edge32", fs_b, 1'b1);
    run_to(36);
    chk("row1_rows", rows_a, 3'b010);
    chk("row1_cols", cols_a, 3'b101);
    run_to(42);
    chk("blank_rows", rows_a, 3'b000);
    chk("blank_cols", cols_a, 3'b111);
    run_to(44);
    chk("row2_rows", rows_a, 3'b100);
    chk("row2_cols", cols_a, 3'b000);
    run_to(52);
    chk("b_row2_rows", rows_b, 4'b1011);
    chk("b_row2_cols", cols_b, 5'b00000);
    run_to(60);
    chk("b_row3_rows", rows_b, 4'b0111);
    chk("b_row3_cols", cols_b, 5'b10000);

    // Back-pressure: three frames offered back to back
    sent = 0;
    pix_a = frames[0]; val_a = 1'b1;
    for (int k = 0; k < 100 && sent < 3; k++) begin
      if (rdy_a) begin
        acc_edge[sent] = a_cnt + 1;
        sent++;
      end
      cycle();
      if (sent < 3 && sent > 0) pix_a = frames[sent];
      else if (sent >= 3) val_a = 1'b0;
    end
    val_a = 1'b0;
    chk("bp_accept1", acc_edge[0], 61);
    chk("bp_accept2", acc_edge[1], 73);
    chk("bp_accept3", acc_edge[2], 97);

    // Boundary collision: valid first seen at the frame-boundary edge
    run_to(143);
    pix_a = 9'b011_011_011; val_a = 1'b1;
    cycle();
    val_a = 1'b0;
    chk("collide_ready", rdy_a, 1'b0);
    run_to(148);
    chk("collide_old_frame", cols_a, 3'b011);
    run_to(172);
    chk("collide_new_frame", cols_a, 3'b100);

    // Reset during row 1 with a pending frame
    pix_a = 9'b001_001_001; val_a = 1'b1;
    cycle();
    val_a = 1'b0;
    run_to(180);
    rst_a = 1'b0;
    cycle();
    chk("mid_reset_rows", rows_a, 3'b000);
    chk("mid_reset_cols", cols_a, 3'b111);
    chk("mid_reset_ready", rdy_a, 1'b1);
    chk("mid_reset_fs", fs_a, 1'b0);
    rst_a = 1'b1;
    run_to(4);
    chk("restart_row0_rows", rows_a, 3'b001);
    chk("restart_dark_cols", cols_a, 3'b111);
    run_to(28);
    chk("restart_frame1_rows", rows_a, 3'b001);
    chk("restart_frame1_cols", cols_a, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
